frame_strobe_sequencer: RTL and testbench
=========================================

# frame_strobe_sequencer

Configuration-side controller that writes one fabric column. It takes a valid/ready stream of frame words and presents each word on `FrameData`. It then pulses the matching one-hot `FrameStrobe` bit with guaranteed setup and hold around the strobe. It sits between the bitstream source (UART/SPI config front-end) and the bottom tile of a column, driving the `FrameData`/`FrameStrobe` chain that every tile of the column buffers and forwards.

## Interface
Parameters:
- `FrameBitsPerRow`, 32: width of one frame word and of `FrameData`.
- `MaxFramesPerCol`, 20: frames per column; width of `FrameStrobe`; frame count per column write.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a column write; honoured only in IDLE.
- `abort`  in  1  terminate the column write; honoured in every state.
- `cfg_data`  in  FrameBitsPerRow  frame word.
- `cfg_valid`  in  1  `cfg_data` valid.
- `cfg_ready`  out  1  word accepted on `cfg_valid && cfg_ready`.
- `FrameData`  out  FrameBitsPerRow  registered frame word to the column.
- `FrameStrobe`  out  MaxFramesPerCol  registered one-hot write strobe.
- `frame_idx`  out  ceil(log2(MaxFramesPerCol))  index of the frame currently in progress.
- `busy`  out  1  high when state is not IDLE.
- `done`  out  1  one-cycle pulse after the last frame's HOLD.

## Operation
- States: IDLE, WAIT_WORD, SETUP, STROBE, HOLD.
- IDLE:
  - `start && !abort` -> WAIT_WORD, `frame_idx` <= 0.
  - Otherwise stay in IDLE.
- WAIT_WORD:
  - `cfg_ready` = 1, combinational from state.
  - On handshake: `FrameData` <= `cfg_data`, -> SETUP.
  - With no handshake: stay; no timeout.
- SETUP: -> STROBE. In the same cycle, `FrameStrobe` <= one-hot(`frame_idx`).
- STROBE:
  - `FrameStrobe` is high for exactly this one cycle.
  - -> HOLD, `FrameStrobe` <= 0.
- HOLD:
  - If `frame_idx == MaxFramesPerCol-1`: -> IDLE and `done` <= 1.
  - Else: `frame_idx` += 1 and -> WAIT_WORD.
- `cfg_ready` is 0 in every state except WAIT_WORD.
- `FrameData` changes only on a handshake. It keeps its last value in IDLE, so it is stable from SETUP through HOLD.
- `FrameStrobe` is never multi-hot. It is nonzero only while in STROBE.
- `abort` sampled high in any non-IDLE state:
  - Next state is IDLE; `FrameStrobe` <= 0; `frame_idx` <= 0; no `done`.
  - `FrameData` is unchanged.
  - A word presented in that same cycle is not accepted, because `cfg_ready` is gated by `!abort`.
- `start` while busy is ignored. `start` together with `abort` in IDLE: `abort` wins and the block stays in IDLE.
- `start` in the cycle `done` is high is accepted (back-to-back columns).
- The `frame_idx` increment never wraps: the last frame exits to IDLE.
- Reset (asserted asynchronously, mid-operation included):
  - State goes to IDLE.
  - `FrameData` = 0, `FrameStrobe` = 0, `frame_idx` = 0, `done` = 0, `cfg_ready` = 0, `busy` = 0.

## Timing
- Handshake on edge t (WAIT_WORD):
  - `FrameData` is valid from t+1 (SETUP).
  - The strobe bit is high in cycle t+2 (STROBE) and low at t+3 (HOLD).
  - `cfg_ready` rises again at t+4 (WAIT_WORD), or `done` is high at t+4 for the last frame.
- Data setup before strobe: 1 cycle. Hold after strobe: at least 1 cycle, since `FrameData` cannot change before the next handshake at t+4 or later.
- Peak throughput: one frame per 4 cycles. A full column takes at least 4*MaxFramesPerCol cycles plus 1 cycle from `start`.
- `start` at edge s gives `cfg_ready` = 1 at s+1.
- `busy` rises at s+1 and falls in the cycle `done` is high.
- All outputs except `cfg_ready` and `busy` are registered. `cfg_ready` and `busy` are decoded from the state register only, with `cfg_ready` also gated by `abort`; no input-to-output paths besides that.

## Test plan
- Reset values: hold `resetn` low with random inputs -> all outputs 0. Release, then `start` -> `cfg_ready` = 1 on the next cycle.
- Full column, `cfg_valid` tied high, words 0xA5A50000+i:
  - Strobe 1<<i is seen one cycle after `FrameData` = 0xA5A50000+i, for i = 0..19.
  - Exactly 20 strobe pulses, each one cycle wide.
  - `done` pulses once, 80 cycles after the first `cfg_ready`.
- Backpressure: `cfg_valid` low for 7 cycles inside WAIT_WORD of frame 3 -> no strobe, `FrameData` unchanged, `frame_idx` = 3 throughout.
- `abort` during STROBE of frame 5 -> strobe bit 5 high only in that cycle. Next cycle: IDLE, `FrameStrobe` = 0, `frame_idx` = 0, no `done`. A new `start` writes frames again from index 0.
- Asynchronous `resetn` pulse mid-SETUP of frame 10 -> outputs clear immediately, no strobe follows. `start` with `abort` in IDLE -> stays IDLE.
- Back-to-back: `start` high in the `done` cycle -> `cfg_ready` next cycle with `frame_idx` = 0. `start` while busy is ignored (strobe count still 20).

Source files
------------

// File: rtl/frame_strobe_sequencer.sv
// ==== frame_strobe_sequencer : stream of frame words -> FrameData + one-hot FrameStrobe column writer ====
// ==== rev 1.0                                                                                             ====
`default_nettype none

module frame_strobe_sequencer #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  localparam int IdxW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       abort,
  input  logic [FrameBitsPerRow-1:0] cfg_data,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [IdxW-1:0]            frame_idx,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_WORD = 3'd1,
    ST_SETUP     = 3'd2,
    ST_STROBE    = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

  localparam logic [IdxW-1:0]            LastIdx   = IdxW'(MaxFramesPerCol - 1);
  localparam logic [MaxFramesPerCol-1:0] StrobeOne = MaxFramesPerCol'(1);

  state_t                       state;
  state_t                       state_nxt;
  logic [FrameBitsPerRow-1:0]   data_nxt;
  logic [MaxFramesPerCol-1:0]   strobe_nxt;
  logic [IdxW-1:0]              idx_nxt;
  logic                         done_nxt;

  // abort gates the handshake so a word offered in the abort cycle is never consumed
  assign cfg_ready = (state == ST_WAIT_WORD) && !abort;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nxt  = state;
    data_nxt   = FrameData;
    strobe_nxt = '0;
    idx_nxt    = frame_idx;
    done_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nxt = ST_WAIT_WORD;
          idx_nxt   = '0;
        end
      end
      ST_WAIT_WORD: begin
        if (cfg_valid && cfg_ready) begin
          data_nxt  = cfg_data;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_nxt  = ST_STROBE;
        strobe_nxt = StrobeOne << frame_idx;
      end
      ST_STROBE: begin
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (frame_idx == LastIdx) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          idx_nxt   = frame_idx + IdxW'(1);
          state_nxt = ST_WAIT_WORD;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (abort && (state != ST_IDLE)) begin
      state_nxt  = ST_IDLE;
      strobe_nxt = '0;
      idx_nxt    = '0;
      done_nxt   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      FrameData   <= '0;
      FrameStrobe <= '0;
      frame_idx   <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      FrameData   <= data_nxt;
      FrameStrobe <= strobe_nxt;
      frame_idx   <= idx_nxt;
      done        <= done_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_strobe_sequencer.sv
// ==== tb_frame_strobe_sequencer : directed self-checking bench for frame_strobe_sequencer (rev 1.0) ====
`default_nettype none

module tb_frame_strobe_sequencer;

  localparam int FB = 32;
  localparam int MF = 20;
  localparam int IW = 5;

  logic          CLK = 1'b0;
  logic          resetn;
  logic          start;
  logic          abort;
  logic [FB-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [FB-1:0] FrameData;
  logic [MF-1:0] FrameStrobe;
  logic [IW-1:0] frame_idx;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  frame_strobe_sequencer #(.FrameBitsPerRow(FB), .MaxFramesPerCol(MF)) dut (
    .CLK(CLK), .resetn(resetn), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .FrameData(FrameData), .FrameStrobe(FrameStrobe), .frame_idx(frame_idx),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // advance one cycle; outputs are sampled and inputs changed 1ns after the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int j = 0; j < 3; j++) begin
      start = 1'($urandom); abort = 1'($urandom); cfg_valid = 1'($urandom); cfg_data = $urandom;
      step();
    end
    checks++; if (FrameData !== '0)   begin errors++; $display("FAIL reset_data got %h exp 0", FrameData); end
    checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL reset_strobe got %h exp 0", FrameStrobe); end
    checks++; if (frame_idx !== '0)   begin errors++; $display("FAIL reset_idx got %0d exp 0", frame_idx); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", cfg_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    start = 1'b1; abort = 1'b0; cfg_valid = 1'b0;
    resetn = 1'b1;
    step();
    start = 1'b0;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL start_ready got %b exp 1", cfg_ready); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL start_busy got %b exp 1", busy); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got %b exp 0", busy); end
  endtask

  // full column with cfg_valid tied high; start_hold keeps start asserted throughout, done cycle included
  task automatic test_full_column(input bit start_hold);
    logic [FB-1:0] base = 32'hA5A5_0000;
    logic [MF-1:0] exp_strobe;
    int pulses = 0;
    int dones  = 0;
    int i;
    start = 1'b1; abort = 1'b0; cfg_valid = 1'b1; cfg_data = base;
    step();
    start = start_hold;
    for (int k = 0; k <= 80; k++) begin
      i = k / 4;
      cfg_data = base + FB'(i);
      if (FrameStrobe != '0) pulses++;
      if (done === 1'b1) dones++;
      if (k == 80) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL col_done got %b exp 1 at cycle %0d", done, k); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL col_busy_done got %b exp 0", busy); end
      end else begin
        case (k % 4)
          0: begin
            checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL col_ready got %b exp 1 frame %0d", cfg_ready, i); end
            checks++; if (frame_idx !== IW'(i)) begin errors++; $display("FAIL col_idx got %0d exp %0d", frame_idx, i); end
            checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL col_strobe_wait got %h exp 0", FrameStrobe); end
          end
          1: begin
            checks++; if (FrameData !== base + FB'(i)) begin errors++; $display("FAIL col_data got %h exp %h", FrameData, base + FB'(i)); end
            checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL col_strobe_setup got %h exp 0", FrameStrobe); end
          end
          2: begin
            exp_strobe = MF'(1) << i;
            checks++; if (FrameStrobe !== exp_strobe) begin errors++; $display("FAIL col_strobe got %h exp %h", FrameStrobe, exp_strobe); end
            checks++; if (FrameData !== base + FB'(i)) begin errors++; $display("FAIL col_data_strobe got %h exp %h", FrameData, base + FB'(i)); end
          end
          default: begin
            checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL col_strobe_hold got %h exp 0", FrameStrobe); end
            checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL col_ready_hold got %b exp 0", cfg_ready); end
          end
        endcase
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL col_done_early got %b exp 0 at cycle %0d", done, k); end
      end
      if (k != 80) step();
    end
    checks++; if (pulses != 20) begin errors++; $display("FAIL col_pulses got %0d exp 20", pulses); end
    checks++; if (dones != 1) begin errors++; $display("FAIL col_done_count got %0d exp 1", dones); end
  endtask

  task automatic test_back_to_back();
    test_full_column(1'b1);
    step();
    start = 1'b0;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", cfg_ready); end
    checks++; if (frame_idx !== '0)   begin errors++; $display("FAIL b2b_idx got %0d exp 0", frame_idx); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL b2b_done got %b exp 0", done); end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [FB-1:0] base = 32'h3C3C_0000;
    start = 1'b1; cfg_valid = 1'b1; cfg_data = base;
    step();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cfg_data = base + FB'(k / 4);
      step();
    end
    cfg_valid = 1'b0;
    cfg_data  = 32'hFFFF_FFFF;
    for (int j = 0; j < 7; j++) begin
      checks++; if (FrameStrobe !== '0)  begin errors++; $display("FAIL bp_strobe got %h exp 0", FrameStrobe); end
      checks++; if (frame_idx !== IW'(3)) begin errors++; $display("FAIL bp_idx got %0d exp 3", frame_idx); end
      checks++; if (FrameData !== base + 32'd2) begin errors++; $display("FAIL bp_data got %h exp %h", FrameData, base + 32'd2); end
      step();
    end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL bp_ready got %b exp 1", cfg_ready); end
    cfg_valid = 1'b1; cfg_data = base + 32'd3;
    step();
    checks++; if (FrameData !== base + 32'd3) begin errors++; $display("FAIL bp_data_resume got %h exp %h", FrameData, base + 32'd3); end
    step();
    checks++; if (FrameStrobe !== 20'h00008) begin errors++; $display("FAIL bp_strobe_resume got %h exp 00008", FrameStrobe); end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_abort();
    logic [FB-1:0] base  = 32'h5A5A_0000;
    logic [FB-1:0] base2 = 32'h1234_5678;
    start = 1'b1; cfg_valid = 1'b1; cfg_data = base;
    step();
    start = 1'b0;
    for (int k = 0; k < 22; k++) begin
      cfg_data = base + FB'(k / 4);
      step();
    end
    checks++; if (FrameStrobe !== 20'h00020) begin errors++; $display("FAIL ab_strobe got %h exp 00020", FrameStrobe); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL ab_busy got %b exp 0", busy); end
    checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL ab_strobe_after got %h exp 0", FrameStrobe); end
    checks++; if (frame_idx !== '0)   begin errors++; $display("FAIL ab_idx got %0d exp 0", frame_idx); end
    checks++; if (FrameData !== base + 32'd5) begin errors++; $display("FAIL ab_data got %h exp %h", FrameData, base + 32'd5); end
    for (int j = 0; j < 3; j++) begin
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL ab_done got %b exp 0", done); end
      step();
    end
    start = 1'b1; cfg_data = base2;
    step();
    start = 1'b0;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ab_restart_ready got %b exp 1", cfg_ready); end
    checks++; if (frame_idx !== '0)   begin errors++; $display("FAIL ab_restart_idx got %0d exp 0", frame_idx); end
    step();
    checks++; if (FrameData !== base2) begin errors++; $display("FAIL ab_restart_data got %h exp %h", FrameData, base2); end
    step();
    checks++; if (FrameStrobe !== 20'h00001) begin errors++; $display("FAIL ab_restart_strobe got %h exp 00001", FrameStrobe); end
    step();
    step();
    cfg_data = 32'hDEAD_BEEF; abort = 1'b1;
    #1;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ab_ready_gate got %b exp 0", cfg_ready); end
    step();
    abort = 1'b0;
    checks++; if (FrameData !== base2) begin errors++; $display("FAIL ab_no_accept got %h exp %h", FrameData, base2); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL ab_wait_busy got %b exp 0", busy); end
  endtask

  task automatic test_async_reset();
    logic [FB-1:0] base = 32'h0F0F_0000;
    start = 1'b1; cfg_valid = 1'b1; cfg_data = base;
    step();
    start = 1'b0;
    for (int k = 0; k < 41; k++) begin
      cfg_data = base + FB'(k / 4);
      step();
    end
    checks++; if (FrameData !== base + 32'd10) begin errors++; $display("FAIL ar_setup_data got %h exp %h", FrameData, base + 32'd10); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (FrameData !== '0)   begin errors++; $display("FAIL ar_data got %h exp 0", FrameData); end
    checks++; if (frame_idx !== '0)   begin errors++; $display("FAIL ar_idx got %0d exp 0", frame_idx); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL ar_busy got %b exp 0", busy); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ar_ready got %b exp 0", cfg_ready); end
    step();
    resetn = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      checks++; if (FrameStrobe !== '0) begin errors++; $display("FAIL ar_no_strobe got %h exp 0", FrameStrobe); end
    end
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL start_abort_busy got %b exp 0", busy); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL start_abort_ready got %b exp 0", cfg_ready); end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    test_reset();
    test_full_column(1'b0);
    start = 1'b0;
    step();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
